parking_exit_gate: RTL and testbench
====================================

# parking_exit_gate

Exit-side controller for the four-spot parking lot, and the other end of the lot's `exit`/`switch` interface. It keeps a per-spot parking-time counter and accepts a driver's exit request for a spot. It presents the fee, waits for payment, then issues the one-cycle `exit` pulse with the spot number to the lot controller. Finally it holds the exit barrier open for a fixed time.

## Interface
Parameters:
- `TIME_W`, default 8: width of each per-spot time counter and of `fee`.
- `GATE_OPEN_CYCLES`, default 4: number of cycles the exit barrier stays open (≥1).

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; asynchronous, active-low. Clears all state.
- `tick`  in  1  time-base pulse, one cycle wide; one tick is one billing unit.
- `F`  in  4  occupied-spot mask from the lot; bit i = spot i occupied.
- `park_evt`  in  1  one-cycle pulse: a car was just parked.
- `park_spot`  in  2  spot index for `park_evt`.
- `req`  in  1  driver exit request (ticket inserted); one-cycle pulse.
- `req_spot`  in  2  spot index for `req`.
- `paid`  in  1  payment confirmed.
- `cancel`  in  1  driver aborts the transaction.
- `exit`  out  1  one-cycle pulse to the lot: free a spot.
- `spot`  out  2  spot index qualified by `exit`; holds the last value otherwise.
- `fee`  out  TIME_W  amount due; valid while `fee_valid`=1.
- `fee_valid`  out  1  high in the CHARGE state.
- `busy`  out  1  high in any state other than IDLE.
- `door_open`  out  1  exit barrier open.
- `err`  out  1  one-cycle pulse: request rejected.

## Operation
Time counters `t[0..3]`, each TIME_W bits:
- If `park_evt`=1 and `park_spot`=i, then `t[i]` is cleared to 0. Clearing has priority over a `tick` in the same cycle.
- Otherwise, if `tick`=1 and `F[i]`=1, then `t[i]` increments, saturating at 2^TIME_W−1. There is no wrap.
- In the RELEASE state, the counter of the spot being freed is cleared.
- Counters keep running in every state.

State machine (IDLE, CHARGE, RELEASE, OPEN):
- IDLE
  - `req`=1 and `F[req_spot]`=1: latch `req_spot` into `spot`. Latch `fee` = max(`t[req_spot]`, 1), so the minimum charge is 1. Go to CHARGE.
  - `req`=1 and `F[req_spot]`=0: pulse `err` for one cycle and stay in IDLE.
- CHARGE
  - `fee_valid`=1 and `fee` is held stable.
  - `paid`=1: go to RELEASE. If `paid` and `cancel` are both 1 in the same cycle, `paid` wins.
  - `cancel`=1 alone: go to IDLE. No `exit` is issued and the counter is untouched.
- RELEASE
  - `exit`=1 for exactly this one cycle.
  - Clear `t[spot]`.
  - Go to OPEN.
- OPEN
  - `door_open`=1 for exactly GATE_OPEN_CYCLES cycles, counted by an internal down-counter.
  - Then go to IDLE.

Other rules:
- `req` arriving while `busy`=1 is ignored silently: no `err` and no latch.
- `paid` and `cancel` outside CHARGE are ignored.
- `park_evt` is honoured in every state.

## Timing
Reset values (on `RST`=0):
- State is IDLE.
- All `t[i]`=0.
- `exit`=0, `spot`=0, `fee`=0, `fee_valid`=0, `busy`=0, `door_open`=0, `err`=0.
- Reset taking effect mid-transaction abandons it: no `exit` pulse is issued and the barrier closes immediately.

Cycle timing:
- `req` sampled at edge n: `fee_valid`, `busy` and `fee` are valid from cycle n+1.
- `fee` is computed from the counter value before edge n. A `tick` at edge n is not included.
- `paid` sampled at edge m in CHARGE: `exit`=1 during cycle m+1.
- `door_open`=1 during cycles m+2 through m+1+GATE_OPEN_CYCLES, then IDLE from cycle m+2+GATE_OPEN_CYCLES.
- Minimum turnaround from `req` to the next accepted `req` is 3+GATE_OPEN_CYCLES cycles.
- `err` is asserted in the cycle after the offending `req`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
1. Park and bill:
   - Stimulus: `park_evt` on spot 2, hold `F`=4'b0100, apply 5 `tick`s, then `req` spot 2.
   - Required: `fee`=5 and `fee_valid`=1 next cycle.
   - Then `paid`: next cycle `exit`=1 with `spot`=2; `door_open` high for 4 cycles; `t[2]` reads 0 afterwards.
2. Minimum fee and saturation:
   - Stimulus: `req` spot 0 immediately after parking.
   - Required: `fee`=1.
   - Stimulus: with TIME_W=8, apply 300 ticks to spot 1, then `req`.
   - Required: `fee`=255.
3. Empty-spot request:
   - Stimulus: `F`=4'b0000, `req` spot 3.
   - Required: `err`=1 for one cycle, `busy` stays 0, `exit` never asserted.
4. Cancel and priority:
   - Stimulus: `cancel` in CHARGE.
   - Required: IDLE next cycle, no `exit`, counter unchanged.
   - Stimulus: `paid` and `cancel` together.
   - Required: `exit` pulse issued.
5. Busy and simultaneous events:
   - Stimulus: `req` for spot 1 while in OPEN.
   - Required: ignored; no `err`.
   - Stimulus: `park_evt` on spot 0 in the same cycle as a `tick`, with `F[0]`=1.
   - Required: `t[0]`=0.
6. Reset mid-operation:
   - Stimulus: assert `RST`=0 asynchronously during OPEN and during CHARGE.
   - Required: all outputs are immediately at their reset values, state is IDLE, and no `exit` pulse occurs after release.

Source files
------------

// File: rtl/parking_exit_gate_if.sv
// -----------------------------------------------------------------------------
// parking_exit_gate_if
//   Bundles the exit gate's lot-side and driver-side signals.
//
//   Handshake semantics: req, paid, cancel, park_evt and tick are single-cycle
//   qualifiers sampled on the rising clock edge. There is no ready/back-pressure.
//   The gate reports whether it can take a request through busy:
//     - a req seen while busy=1 is dropped silently;
//     - exit qualifies spot for exactly one cycle;
//     - fee is meaningful only while fee_valid=1.
//
//   Signals:
//     tick, F, park_evt, park_spot     lot/time-base inputs to the gate
//     req, req_spot, paid, cancel      driver inputs to the gate
//     exit, spot                       free-spot pulse back to the lot
//     fee, fee_valid, busy, door_open  status outputs
//     err                              rejected-request pulse
//     dbg_state                        current gate state (debug)
//   Modports: master = environment side, slave = gate side.
// -----------------------------------------------------------------------------
interface parking_exit_gate_if #(
    parameter int TIME_W = 8
);
    logic              tick;
    logic [3:0]        F;
    logic              park_evt;
    logic [1:0]        park_spot;
    logic              req;
    logic [1:0]        req_spot;
    logic              paid;
    logic              cancel;
    logic              exit;
    logic [1:0]        spot;
    logic [TIME_W-1:0] fee;
    logic              fee_valid;
    logic              busy;
    logic              door_open;
    logic              err;
    logic [1:0]        dbg_state;

    modport master (
        output tick, F, park_evt, park_spot, req, req_spot, paid, cancel,
        input  exit, spot, fee, fee_valid, busy, door_open, err, dbg_state
    );

    modport slave (
        input  tick, F, park_evt, park_spot, req, req_spot, paid, cancel,
        output exit, spot, fee, fee_valid, busy, door_open, err, dbg_state
    );
endinterface

// File: rtl/parking_exit_gate.sv
// -----------------------------------------------------------------------------
// parking_exit_gate
//   Exit-side controller for a four-spot lot. It keeps one parking-time counter
//   per spot. It accepts an exit request and presents the fee, then waits for
//   payment or cancel. On payment it pulses exit/spot to the lot controller and
//   holds the barrier open for GATE_OPEN_CYCLES cycles.
//
//   Ports:
//     CLK   clock, rising edge
//     RST   asynchronous active-low reset
//     bus   parking_exit_gate_if.slave (see interface header for signals)
//   All outputs are registered.
// -----------------------------------------------------------------------------
module parking_exit_gate #(
    parameter int TIME_W           = 8,
    parameter int GATE_OPEN_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    parking_exit_gate_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHARGE  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_OPEN    = 2'd3
    } state_t;

    // The down-counter is loaded with GATE_OPEN_CYCLES-1 and the gate closes on
    // the cycle it reads zero, so the barrier stays open for exactly
    // GATE_OPEN_CYCLES cycles.
    localparam int                CNT_W    = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(GATE_OPEN_CYCLES - 1);
    localparam logic [TIME_W-1:0] T_MAX    = '1;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] t_q [4];
    logic [TIME_W-1:0] t_d [4];
    logic [TIME_W-1:0] fee_q, fee_d;
    logic [1:0]        spot_q, spot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              exit_q, exit_d;
    logic              fee_valid_q, fee_valid_d;
    logic              busy_q, busy_d;
    logic              door_open_q, door_open_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        fee_d   = fee_q;
        spot_d  = spot_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        t_d     = t_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (bus.F[bus.req_spot]) begin
                        state_d = ST_CHARGE;
                        spot_d  = bus.req_spot;
                        // Minimum charge is one billing unit.
                        fee_d   = (t_q[bus.req_spot] == '0) ? TIME_W'(1) : t_q[bus.req_spot];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CHARGE: begin
                // paid wins over a simultaneous cancel
                if (bus.paid) begin
                    state_d = ST_RELEASE;
                end else if (bus.cancel) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_OPEN;
                cnt_d   = CNT_LOAD;
            end
            ST_OPEN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clearing (new car parked, or spot being freed) beats a tick.
        for (int i = 0; i < 4; i++) begin
            if ((bus.park_evt && bus.park_spot == 2'(i)) ||
                (state_q == ST_RELEASE && spot_q == 2'(i))) begin
                t_d[i] = '0;
            end else if (bus.tick && bus.F[i] && t_q[i] != T_MAX) begin
                t_d[i] = t_q[i] + TIME_W'(1);
            end
        end

        // Status outputs follow the next state so they line up with it.
        exit_d      = (state_d == ST_RELEASE);
        fee_valid_d = (state_d == ST_CHARGE);
        busy_d      = (state_d != ST_IDLE);
        door_open_d = (state_d == ST_OPEN);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            fee_q       <= '0;
            spot_q      <= '0;
            cnt_q       <= '0;
            exit_q      <= 1'b0;
            fee_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            door_open_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                t_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fee_q       <= fee_d;
            spot_q      <= spot_d;
            cnt_q       <= cnt_d;
            exit_q      <= exit_d;
            fee_valid_q <= fee_valid_d;
            busy_q      <= busy_d;
            door_open_q <= door_open_d;
            err_q       <= err_d;
            for (int i = 0; i < 4; i++) begin
                t_q[i] <= t_d[i];
            end
        end
    end

    assign bus.exit      = exit_q;
    assign bus.spot      = spot_q;
    assign bus.fee       = fee_q;
    assign bus.fee_valid = fee_valid_q;
    assign bus.busy      = busy_q;
    assign bus.door_open = door_open_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_parking_exit_gate.sv
// -----------------------------------------------------------------------------
// tb_parking_exit_gate
//   Bench for parking_exit_gate. It uses a vector table for the basic
//   park/bill/pay flow, hand-written corner sequences, and random stimulus.
//   All of it is checked against a timestamp-based reference model.
// -----------------------------------------------------------------------------
module tb_parking_exit_gate;

    localparam int TIME_W = 8;
    localparam int G      = 4;
    localparam int T_SAT  = (1 << TIME_W) - 1;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    parking_exit_gate_if #(.TIME_W(TIME_W)) bus ();

    parking_exit_gate #(.TIME_W(TIME_W), .GATE_OPEN_CYCLES(G)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The model works from transaction timestamps rather than states.
    // m_x is the edge at which payment was taken.
    //   exit      = after edge m_x
    //   door_open = after edges m_x+1 .. m_x+G
    //   counter   = cleared at edge m_x+1
    int m_t [4];
    bit m_charge;
    int m_x;
    int m_e = 0;
    int m_fee;
    int m_spot;
    bit m_err;

    function automatic bit m_busy(input int e);
        return m_charge || (m_x >= 0 && e <= m_x + G);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_t[i] = 0;
        m_charge = 0;
        m_x      = -1;
        m_fee    = 0;
        m_spot   = 0;
        m_err    = 0;
    endtask

    task automatic model_edge(input bit tk, input bit [3:0] f, input bit pe, input int ps,
                              input bit rq, input int rs, input bit pd, input bit cn);
        bit busy_before;
        bit charge_before;
        int clr_spot;
        busy_before   = m_busy(m_e);
        charge_before = m_charge;
        m_e++;
        clr_spot = (m_x >= 0 && m_e == m_x + 1) ? m_spot : -1;
        m_err = 0;
        if (!busy_before && rq) begin
            if (f[rs]) begin
                m_charge = 1;
                m_fee    = (m_t[rs] > 0) ? m_t[rs] : 1;
                m_spot   = rs;
            end else begin
                m_err = 1;
            end
        end else if (charge_before) begin
            if (pd) begin
                m_charge = 0;
                m_x      = m_e;
            end else if (cn) begin
                m_charge = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if ((pe && ps == i) || clr_spot == i) m_t[i] = 0;
            else if (tk && f[i] && m_t[i] < T_SAT) m_t[i] = m_t[i] + 1;
        end
    endtask

    task automatic compare_model();
        chk("exit",      bus.exit,      (m_x >= 0 && m_e == m_x));
        chk("door_open", bus.door_open, (m_x >= 0 && m_e >= m_x + 1 && m_e <= m_x + G));
        chk("busy",      bus.busy,      m_busy(m_e));
        chk("fee_valid", bus.fee_valid, m_charge);
        chk("err",       bus.err,       m_err);
        chk("spot",      bus.spot,      m_spot);
        chk("fee",       bus.fee,       m_fee);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, let the rising edge sample, check at the
    // next falling edge.
    task automatic cyc(input bit tk, input bit [3:0] f, input bit pe, input bit [1:0] ps,
                       input bit rq, input bit [1:0] rs, input bit pd, input bit cn);
        bus.tick = tk; bus.F = f; bus.park_evt = pe; bus.park_spot = ps;
        bus.req = rq; bus.req_spot = rs; bus.paid = pd; bus.cancel = cn;
        @(posedge CLK);
        model_edge(tk, f, pe, int'(ps), rq, int'(rs), pd, cn);
        @(negedge CLK);
        compare_model();
    endtask

    task automatic idle(input bit [3:0] f, input int n);
        for (int i = 0; i < n; i++) cyc(0, f, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_exit"},      bus.exit,      0);
        chk({tag, "_spot"},      bus.spot,      0);
        chk({tag, "_fee"},       bus.fee,       0);
        chk({tag, "_fee_valid"}, bus.fee_valid, 0);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_door_open"}, bus.door_open, 0);
        chk({tag, "_err"},       bus.err,       0);
        chk({tag, "_state"},     bus.dbg_state, 0);
    endtask

    // Asynchronous reset in the middle of a clock phase.
    task automatic mid_reset(input string tag);
        #2 RST = 1'b0;
        #1 chk_reset_outputs(tag);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit       tk;
        bit [3:0] f;
        bit       pe;
        bit [1:0] ps;
        bit       rq;
        bit [1:0] rs;
        bit       pd;
        bit       cn;
        bit       e_exit;
        int       e_spot;
        int       e_fee;
        bit       e_fv;
        bit       e_busy;
        bit       e_door;
        bit       e_err;
    } vec_t;

    function automatic vec_t mk(input bit tk, input bit pe, input bit rq, input bit [1:0] rs,
                                input bit pd, input bit cn, input bit e_exit, input int e_spot,
                                input int e_fee, input bit e_fv, input bit e_busy,
                                input bit e_door, input bit e_err);
        vec_t v;
        v.tk = tk; v.f = 4'b0100; v.pe = pe; v.ps = 2'd2; v.rq = rq; v.rs = rs;
        v.pd = pd; v.cn = cn; v.e_exit = e_exit; v.e_spot = e_spot; v.e_fee = e_fee;
        v.e_fv = e_fv; v.e_busy = e_busy; v.e_door = e_door; v.e_err = e_err;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        bit [3:0] rf;

        //          tk pe rq rs pd cn | exit spot fee fv busy door err
        vecs[0]  = mk(0, 1, 0, 0, 0, 0,   0,   0,   0,  0, 0,   0,   0);
        for (int i = 1; i <= 5; i++)
            vecs[i] = mk(1, 0, 0, 0, 0, 0, 0,   0,   0,  0, 0,   0,   0);
        vecs[6]  = mk(0, 0, 1, 2, 0, 0,   0,   2,   5,  1, 1,   0,   0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,   0,   2,   5,  1, 1,   0,   0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 0,   1,   2,   5,  0, 1,   0,   0);
        for (int i = 9; i <= 12; i++)
            vecs[i] = mk(0, 0, 0, 0, 0, 0, 0,   2,   5,  0, 1,   1,   0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0,   0,   2,   5,  0, 0,   0,   0);
        vecs[14] = mk(0, 0, 1, 2, 0, 0,   0,   2,   1,  1, 1,   0,   0);
        vecs[15] = mk(0, 0, 0, 0, 0, 1,   0,   2,   1,  0, 0,   0,   0);
        vecs[16] = mk(0, 0, 1, 3, 0, 0,   0,   2,   1,  0, 0,   0,   1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0,   0,   2,   1,  0, 0,   0,   0);

        bus.tick = 0; bus.F = 0; bus.park_evt = 0; bus.park_spot = 0;
        bus.req = 0; bus.req_spot = 0; bus.paid = 0; bus.cancel = 0;
        model_reset();

        // Reset state
        #12 chk_reset_outputs("reset");
        @(negedge CLK);
        RST = 1'b1;

        // Park and bill, fee cleared after release, cancel, empty-spot error
        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].tk, vecs[i].f, vecs[i].pe, vecs[i].ps, vecs[i].rq, vecs[i].rs,
                vecs[i].pd, vecs[i].cn);
            chk($sformatf("vec%0d_exit", i),      bus.exit,      vecs[i].e_exit);
            chk($sformatf("vec%0d_spot", i),      bus.spot,      vecs[i].e_spot);
            chk($sformatf("vec%0d_fee", i),       bus.fee,       vecs[i].e_fee);
            chk($sformatf("vec%0d_fee_valid", i), bus.fee_valid, vecs[i].e_fv);
            chk($sformatf("vec%0d_busy", i),      bus.busy,      vecs[i].e_busy);
            chk($sformatf("vec%0d_door", i),      bus.door_open, vecs[i].e_door);
            chk($sformatf("vec%0d_err", i),       bus.err,       vecs[i].e_err);
        end

        // Minimum fee right after parking
        cyc(0, 4'b0001, 1, 0, 0, 0, 0, 0);
        cyc(0, 4'b0001, 0, 0, 1, 0, 0, 0);
        chk("min_fee", bus.fee, 1);
        cyc(0, 4'b0001, 0, 0, 0, 0, 0, 1);
        chk("cancel_idle", bus.busy, 0);

        // Saturation after 300 ticks
        cyc(0, 4'b0010, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, 4'b0010, 0, 0, 0, 0, 0, 0);
        cyc(0, 4'b0010, 0, 0, 1, 1, 0, 0);
        chk("sat_fee", bus.fee, T_SAT);
        cyc(0, 4'b0010, 0, 0, 0, 0, 1, 0);
        chk("sat_exit", bus.exit, 1);
        chk("sat_spot", bus.spot, 1);
        idle(4'b0010, 1);
        // Request during OPEN is silently dropped
        cyc(0, 4'b0010, 0, 0, 1, 1, 0, 0);
        chk("busy_req_err", bus.err, 0);
        chk("busy_req_door", bus.door_open, 1);
        idle(4'b0010, 3);
        chk("after_open_idle", bus.busy, 0);

        // Park and tick in the same cycle: clear wins
        for (int i = 0; i < 3; i++) cyc(1, 4'b0001, 0, 0, 0, 0, 0, 0);
        cyc(1, 4'b0001, 1, 0, 0, 0, 0, 0);
        cyc(1, 4'b0001, 0, 0, 0, 0, 0, 0);
        cyc(1, 4'b0001, 0, 0, 0, 0, 0, 0);
        cyc(0, 4'b0001, 0, 0, 1, 0, 0, 0);
        chk("park_tick_fee", bus.fee, 2);
        // paid and cancel together: paid wins
        cyc(0, 4'b0001, 0, 0, 0, 0, 1, 1);
        chk("paid_cancel_exit", bus.exit, 1);
        idle(4'b0001, G + 1);

        // Reset during OPEN
        cyc(1, 4'b0001, 0, 0, 0, 0, 0, 0);
        cyc(0, 4'b0001, 0, 0, 1, 0, 0, 0);
        cyc(0, 4'b0001, 0, 0, 0, 0, 1, 0);
        cyc(0, 4'b0001, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_door", bus.door_open, 1);
        mid_reset("rst_open");
        idle(4'b0001, 3);

        // Reset during CHARGE
        cyc(1, 4'b0001, 0, 0, 0, 0, 0, 0);
        cyc(0, 4'b0001, 0, 0, 1, 0, 0, 0);
        chk("pre_reset_fv", bus.fee_valid, 1);
        mid_reset("rst_charge");
        idle(4'b0001, 3);

        // Random traffic
        rf = 4'b1011;
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) rf = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 1) == 0, rf, $urandom_range(0, 7) == 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
